if_fetch_ctrl: RTL and testbench



---
 rtl/if_ctrl_pkg.sv | 25 ++
 rtl/pc_next_sel.sv | 49 ++++
 rtl/if_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package if_ctrl_pkg;

    // Default widths: 64-bit LEGv8 word, 32-bit instruction.
    localparam int WORD       = 64;
    localparam int INST_SIZE  = 32;
    localparam int INST_BYTES = 4;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    // PCSrc encodings. Any value with bit 1 set (10 or 11) selects the
    // register target, so PCSRC_REG is tested as a mask.
    localparam logic [1:0] PCSRC_INCR   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_REG    = 2'b10;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: pc_q + 4, branch target (ALU_res) or register target (ALUOut).
// Latency: combinational.
// Backpressure: none.
// IF_MISALIGN_CHK_EN: adds align_err instead of forcing target[1:0] to zero.
module pc_next_sel
    import if_ctrl_pkg::*;
#(
    parameter int ADDR_W = WORD
) (
    input  logic [ADDR_W-1:0] pc_q,
    input  logic [1:0]        pcsrc,
    input  logic [ADDR_W-1:0] alu_res,
    input  logic [ADDR_W-1:0] alu_out,
    output logic [ADDR_W-1:0] pc_incr,
    output logic [ADDR_W-1:0] next_pc
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic              align_err
`endif
);

    logic [ADDR_W-1:0] target_raw;

    // Select the redirect target and the sequential successor (wraps modulo 2^ADDR_W)
    always_comb begin
        pc_incr    = pc_q + ADDR_W'(INST_BYTES);
        target_raw = '0;
        if ((pcsrc & PCSRC_REG) != 2'b00) begin
            target_raw = alu_out;
        end else if (pcsrc == PCSRC_BRANCH) begin
            target_raw = alu_res;
        end
        if (pcsrc == PCSRC_INCR) begin
            next_pc = pc_incr;
        end else begin
`ifdef IF_MISALIGN_CHK_EN
            next_pc = target_raw;
`else
            // Without the checker, instruction alignment is imposed by the mux.
            next_pc = target_raw & ~ADDR_W'(INST_BYTES - 1);
`endif
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    assign align_err = (pcsrc != PCSRC_INCR) && (target_raw[1:0] != 2'b00);
`endif

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF fetch sequencer: owns PC, issues imem requests, buffers one instruction for ID.
// Latency: zero-wait imem gives first request 1 cycle and first if_valid 3 cycles after reset release; 2 cycles/instr.
// Backpressure: id_stall holds the buffer and blocks new requests while full; imem_req_ready stalls the issue.
// IF_MISALIGN_CHK_EN: adds if_misalign and parks fetch after a misaligned redirect.
module if_fetch_ctrl
    import if_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = WORD,
    parameter int                INST_W   = INST_SIZE,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [1:0]        PCSrc,
    input  logic [ADDR_W-1:0] ALU_res,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic              id_stall,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_incr
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic              if_misalign
`endif
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_incr;
    logic [ADDR_W-1:0] next_pc;
    logic              redir_take;
    logic              buf_free;
    logic              req_fire;
    logic              fetch_parked;

`ifdef IF_MISALIGN_CHK_EN
    logic align_err;
    logic misalign_q;
    assign fetch_parked = misalign_q;
    assign if_misalign  = misalign_q;
`else
    assign fetch_parked = 1'b0;
`endif

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .pc_q      (pc_q),
        .pcsrc     (PCSrc),
        .alu_res   (ALU_res),
        .alu_out   (ALUOut),
        .pc_incr   (pc_incr),
        .next_pc   (next_pc)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .align_err (align_err)
`endif
    );

    // A redirect only acts once fetching has started; PCSrc = 00 is a no-op.
    assign redir_take = redirect && (PCSrc != PCSRC_INCR) && (state != ST_IDLE);
    // The buffer can take a new instruction if empty or being consumed this cycle,
    // so the request valid looks at id_stall directly rather than a cycle late.
    assign buf_free       = !if_valid || !id_stall;
    assign imem_req_valid = (state == ST_ISSUE) && buf_free && !fetch_parked;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Fetch FSM, PC register and one-entry instruction buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_valid   <= 1'b0;
            if_inst    <= '0;
            if_pc      <= '0;
            if_pc_incr <= '0;
`ifdef IF_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            if (if_valid && !id_stall) begin
                if_valid <= 1'b0;
            end
            if (redir_take) begin
                pc_q     <= next_pc;
                if_valid <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
                misalign_q <= align_err;
`endif
            end
            case (state)
                ST_IDLE: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // A redirect racing an accepted request leaves a stale response to drop.
                    if (req_fire) begin
                        state <= redir_take ? ST_DROP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redir_take) begin
                        state <= imem_rsp_valid ? ST_ISSUE : ST_DROP;
                    end else if (imem_rsp_valid) begin
                        if_inst    <= imem_rsp_data;
                        if_pc      <= pc_q;
                        if_pc_incr <= pc_incr;
                        if_valid   <= 1'b1;
                        pc_q       <= pc_incr;
                        state      <= ST_ISSUE;
                    end
                end
                ST_DROP: begin
                    // The stale response is always consumed here, even alongside a
                    // new redirect, since no further response would ever arrive.
                    if (imem_rsp_valid) begin
                        state <= ST_ISSUE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, reset/misalign sequences, random run vs. stream model.
// Latency: imem model answers 1..3 cycles after acceptance.
// Backpressure: id_stall and imem_req_ready driven from the table or randomly.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [1:0]  PCSrc;
    logic [63:0] ALU_res;
    logic [63:0] ALUOut;
    logic        id_stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic [63:0] if_pc_incr;
`ifdef IF_MISALIGN_CHK_EN
    logic        if_misalign;
`endif

    if_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect       (redirect),
        .PCSrc          (PCSrc),
        .ALU_res        (ALU_res),
        .ALUOut         (ALUOut),
        .id_stall       (id_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pc_incr     (if_pc_incr)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .if_misalign    (if_misalign)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    // imem model state
    logic        pend;
    logic [63:0] pend_addr;
    int          wait_cnt;
    int          cur_lat;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        redir;
        logic [1:0]  pcsrc;
        logic [63:0] alu_res;
        logic [63:0] alu_out;
        int          lat;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_vld;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    localparam int NV = 36;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
    vec_t tbl [NV];

    // Memory image: the word at byte address 4i holds i.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[33:2];
    endfunction

    function automatic vec_t mk(input logic st, input logic rd, input logic rr, input logic [1:0] ps,
                                input logic [63:0] ar, input logic [63:0] ao, input int lat,
                                input logic er, input logic [63:0] ea, input logic ev,
                                input logic [63:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = st; v.ready = rd; v.redir = rr; v.pcsrc = ps; v.alu_res = ar; v.alu_out = ao;
        v.lat = lat; v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    function automatic logic [63:0] rnd_tgt();
        logic [63:0] t;
        t = {32'($urandom), 32'($urandom)};
        if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        return t & ~64'h3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call at the sampling point (negedge): records a handshake, crosses the
    // rising edge and presents the imem response for the new cycle.
    task automatic advance();
        logic        hs;
        logic [63:0] hs_addr;
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (hs) begin
            pend = 1'b1; pend_addr = hs_addr; wait_cnt = cur_lat - 1;
        end
        if (pend) begin
            if (wait_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_at(pend_addr);
                pend           = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_pc;
        logic        exp_known, flush_pend, pend_req;
        logic [63:0] held_addr;
        int          first, beats, n_req;

        // stall ready redir pcsrc alu_res alu_out lat | req addr vld pc inst
        tbl[0]  = mk(0,1,0,0,  0,  0,1, 0,  0, 0,  0, 0);
        tbl[1]  = mk(0,1,0,0,  0,  0,1, 1,  0, 0,  0, 0);
        tbl[2]  = mk(0,1,0,0,  0,  0,1, 0,  0, 0,  0, 0);
        tbl[3]  = mk(0,1,0,0,  0,  0,1, 1,  4, 1,  0, 0);
        tbl[4]  = mk(0,1,0,0,  0,  0,1, 0,  4, 0,  0, 0);
        tbl[5]  = mk(0,1,0,0,  0,  0,1, 1,  8, 1,  4, 1);
        tbl[6]  = mk(0,1,0,0,  0,  0,1, 0,  8, 0,  0, 0);
        tbl[7]  = mk(1,1,0,0,  0,  0,1, 0, 12, 1,  8, 2);
        tbl[8]  = mk(1,1,0,0,  0,  0,1, 0, 12, 1,  8, 2);
        tbl[9]  = mk(1,1,0,0,  0,  0,1, 0, 12, 1,  8, 2);
        tbl[10] = mk(0,0,0,0,  0,  0,1, 1, 12, 1,  8, 2);
        tbl[11] = mk(0,0,0,0,  0,  0,1, 1, 12, 0,  0, 0);
        tbl[12] = mk(0,0,0,0,  0,  0,1, 1, 12, 0,  0, 0);
        tbl[13] = mk(0,0,0,0,  0,  0,1, 1, 12, 0,  0, 0);
        tbl[14] = mk(0,1,0,0,  0,  0,1, 1, 12, 0,  0, 0);
        tbl[15] = mk(0,1,0,0,  0,  0,1, 0, 12, 0,  0, 0);
        tbl[16] = mk(0,1,0,0,  0,  0,2, 1, 16, 1, 12, 3);
        tbl[17] = mk(0,1,1,1,124,  0,1, 0, 16, 0,  0, 0);
        tbl[18] = mk(0,1,0,0,  0,  0,1, 0,124, 0,  0, 0);
        tbl[19] = mk(0,1,0,0,  0,  0,1, 1,124, 0,  0, 0);
        tbl[20] = mk(0,1,0,0,  0,  0,1, 0,124, 0,  0, 0);
        tbl[21] = mk(0,1,1,2,  0, 60,1, 1,128, 1,124,31);
        tbl[22] = mk(0,1,0,0,  0,  0,1, 0, 60, 0,  0, 0);
        tbl[23] = mk(0,1,0,0,  0,  0,1, 1, 60, 0,  0, 0);
        tbl[24] = mk(0,1,1,3,  0, 60,1, 0, 60, 0,  0, 0);
        tbl[25] = mk(0,1,0,0,  0,  0,1, 1, 60, 0,  0, 0);
        tbl[26] = mk(0,1,1,0,300,200,1, 0, 60, 0,  0, 0);
        tbl[27] = mk(0,1,0,0,  0,  0,1, 1, 64, 1, 60,15);
        tbl[28] = mk(0,1,0,0,  0,  0,1, 0, 64, 0,  0, 0);
        tbl[29] = mk(0,1,1,1,TOP,  0,1, 1, 68, 1, 64,16);
        tbl[30] = mk(0,1,0,0,  0,  0,1, 0,TOP, 0,  0, 0);
        tbl[31] = mk(0,1,0,0,  0,  0,1, 1,TOP, 0,  0, 0);
        tbl[32] = mk(0,1,0,0,  0,  0,1, 0,TOP, 0,  0, 0);
        tbl[33] = mk(0,1,0,0,  0,  0,1, 1,  0, 1,TOP,32'hFFFF_FFFF);
        tbl[34] = mk(0,1,0,0,  0,  0,1, 0,  0, 0,  0, 0);
        tbl[35] = mk(0,1,0,0,  0,  0,1, 1,  4, 1,  0, 0);

        rst_n = 1'b1; redirect = 1'b0; PCSrc = 2'b00; ALU_res = '0; ALUOut = '0;
        id_stall = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        pend = 1'b0; pend_addr = '0; wait_cnt = 0; cur_lat = 1;
        #2 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_pc_incr", if_pc_incr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table, one row per cycle after reset release
        for (int i = 0; i < NV; i++) begin
            id_stall = tbl[i].stall; imem_req_ready = tbl[i].ready; redirect = tbl[i].redir;
            PCSrc = tbl[i].pcsrc; ALU_res = tbl[i].alu_res; ALUOut = tbl[i].alu_out;
            cur_lat = tbl[i].lat;
            @(negedge clk);
            chk($sformatf("c%0d_req_valid", i), imem_req_valid, tbl[i].e_req);
            chk($sformatf("c%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("c%0d_if_valid", i), if_valid, tbl[i].e_vld);
            if (tbl[i].e_vld) begin
                chk($sformatf("c%0d_if_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("c%0d_if_inst", i), if_inst, 64'(tbl[i].e_inst));
                chk($sformatf("c%0d_if_pc_incr", i), if_pc_incr, tbl[i].e_pc + 64'd4);
            end
            advance();
        end

        // Reset in the middle of WAIT, with a late response after release
        redirect = 1'b1; PCSrc = 2'b01; ALU_res = 64'd400; id_stall = 1'b0; imem_req_ready = 1'b1;
        cur_lat = 1;
        @(negedge clk);
        advance();
        redirect = 1'b0; cur_lat = 6;
        @(negedge clk);
        chk("pre_rst_addr", imem_addr, 64'd400);
        chk("pre_rst_req", imem_req_valid, 1);
        advance();
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", imem_req_valid, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_if_valid", if_valid, 0);
        chk("arst_if_pc_incr", if_pc_incr, 0);
`ifdef IF_MISALIGN_CHK_EN
        chk("arst_misalign", if_misalign, 0);
`endif
        pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        cur_lat = 1;
        @(negedge clk);
        chk("idle_req_valid", imem_req_valid, 0);
        advance();
        @(negedge clk);
        chk("restart_req", imem_req_valid, 1);
        chk("restart_addr", imem_addr, 0);
        advance();
        first = -1;
        for (int k = 2; k < 12; k++) begin
            @(negedge clk);
            if (if_valid && first < 0) begin
                first = k;
                chk("restart_pc", if_pc, 0);
                chk("restart_inst", if_inst, 0);
            end
            advance();
        end
        chk("first_vld_cycle", 64'(first), 64'd3);

`ifdef IF_MISALIGN_CHK_EN
        // Misaligned redirect parks fetch until an aligned one
        redirect = 1'b1; PCSrc = 2'b01; ALU_res = 64'd126;
        @(negedge clk);
        advance();
        redirect = 1'b0;
        n_req = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) chk("misalign_set", if_misalign, 1);
            if (imem_req_valid) n_req++;
            advance();
        end
        chk("parked_reqs", 64'(n_req), 0);
        redirect = 1'b1; PCSrc = 2'b10; ALUOut = 64'd40;
        @(negedge clk);
        advance();
        redirect = 1'b0;
        first = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) chk("misalign_clr", if_misalign, 0);
            if (if_valid && first < 0) begin
                first = k;
                chk("resume_pc", if_pc, 64'd40);
                chk("resume_inst", if_inst, 64'd10);
            end
            advance();
        end
        chk("resume_seen", 64'(first >= 0), 1);
`else
        n_req = 0;
`endif

        // Random run against an instruction-stream model
        exp_pc = '0; exp_known = 1'b0; flush_pend = 1'b0; pend_req = 1'b0; held_addr = '0; beats = 0;
        for (int c = 0; c < 3000; c++) begin
            id_stall       = ($urandom_range(0, 9) < 3);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            cur_lat        = $urandom_range(1, 3);
            redirect       = (c == 0) || ($urandom_range(0, 19) == 0);
            PCSrc          = (c == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            ALU_res        = rnd_tgt();
            ALUOut         = rnd_tgt();
            @(negedge clk);
            if (flush_pend) chk("rnd_flush", if_valid, 0);
            if (pend_req && imem_req_valid) chk("rnd_addr_hold", imem_addr, held_addr);
            if (if_valid && !id_stall) begin
                if (exp_known) begin
                    chk("rnd_pc", if_pc, exp_pc);
                    chk("rnd_inst", if_inst, 64'(word_at(exp_pc)));
                    chk("rnd_pc_incr", if_pc_incr, exp_pc + 64'd4);
                    beats++;
                end
                exp_pc = exp_pc + 64'd4;
            end
            if (redirect && PCSrc != 2'b00) begin
                exp_pc    = (PCSrc == 2'b01) ? ALU_res : ALUOut;
                exp_known = 1'b1;
            end
            flush_pend = redirect && (PCSrc != 2'b00);
            pend_req   = imem_req_valid && !imem_req_ready && !flush_pend;
            held_addr  = imem_addr;
            advance();
        end
        redirect = 1'b0;
        chk("rnd_progress", 64'(beats >= 100), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
